// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite memory slave: response codes,
// FSM state encoding and the access-latency counter width.
// Pure declarations; no logic, no timing.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Wait-state counter width; LATENCY is limited to 0..15
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/axil_mem_ram.sv
// Single-port DEPTH x 32 word RAM with per-byte write enables.
// Latency: write on the enabled edge; read data registered one edge after re_i.
// Backpressure: none; the caller never asserts we_i and re_i together.
module axil_mem_ram
  import axil_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write and registered read; contents deliberately not reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave over a byte-enabled word RAM; optional AXIL_MEM_DECERR_EN decodes the BASE window.
// Latency: B/R valid LATENCY+2 edges after the last AW/W handshake or the AR handshake.
// Backpressure: one-entry AW/W/AR buffers; readies stay low until the owning B/R handshake.
module axil_mem_slave
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h01000000,
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  // Channel buffers
  logic              awready_q, wready_q, arready_q;
  logic              aw_full_q, w_full_q, ar_full_q;
  logic              aw_full_d, w_full_d, ar_full_d;
  logic [ADDR_W-1:0] aw_idx_q, ar_idx_q;
  logic              aw_ok_q, ar_ok_q;
  logic [31:0]       w_dat_q;
  logic [3:0]        w_strb_q;

  // FSM and response registers
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_rd_q;
  logic             bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_in_win, ar_in_win;
  logic wr_pend, rd_pend, go_wr, go_rd, wait_done;
  logic ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_rdata;
  logic unused_bits;

`ifdef AXIL_MEM_DECERR_EN
  localparam int HI = ADDR_W + 2;
  assign aw_in_win   = (s_axi_awaddr[31:HI] == BASE[31:HI]);
  assign ar_in_win   = (s_axi_araddr[31:HI] == BASE[31:HI]);
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], BASE[HI-1:0]};
`else
  // Window aliases across the whole address space
  assign aw_in_win   = 1'b1;
  assign ar_in_win   = 1'b1;
  assign unused_bits = ^{s_axi_awaddr[31:ADDR_W+2], s_axi_awaddr[1:0],
                         s_axi_araddr[31:ADDR_W+2], s_axi_araddr[1:0], BASE};
`endif

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid  & wready_q;
  assign ar_hs = s_axi_arvalid & arready_q;
  assign b_hs  = bvalid_q & s_axi_bready;
  assign r_hs  = rvalid_q & s_axi_rready;

  // Buffer occupancy: fill on channel handshake, empty on the response handshake
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    ar_full_d = ar_full_q;
    if (aw_hs) aw_full_d = 1'b1;
    if (w_hs)  w_full_d  = 1'b1;
    if (ar_hs) ar_full_d = 1'b1;
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (r_hs) ar_full_d = 1'b0;
  end

  // Buffer state, payload capture and registered readies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_idx_q  <= '0;
      ar_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      ar_ok_q   <= 1'b0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      arready_q <= ~ar_full_d;
      if (aw_hs) begin
        aw_idx_q <= s_axi_awaddr[ADDR_W+1:2];
        aw_ok_q  <= aw_in_win;
      end
      if (w_hs) begin
        w_dat_q  <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (ar_hs) begin
        ar_idx_q <= s_axi_araddr[ADDR_W+1:2];
        ar_ok_q  <= ar_in_win;
      end
    end
  end

  // Arbitration: when both ops contend, the one opposite to last_rd wins
  assign wr_pend   = aw_full_q & w_full_q;
  assign rd_pend   = ar_full_q;
  assign go_rd     = (state_q == ST_IDLE) & rd_pend & (~wr_pend | ~last_rd_q);
  assign go_wr     = (state_q == ST_IDLE) & wr_pend & (~rd_pend | last_rd_q);
  assign wait_done = (cnt_q == LAT_C);

  // Read is launched on WAIT entry so the RAM output is settled by the R edge;
  // the write commits on the same edge that raises bvalid.
  assign ram_re   = go_rd;
  assign ram_we   = (state_q == ST_WR_WAIT) & wait_done & aw_ok_q;
  assign ram_addr = (state_q == ST_WR_WAIT) ? aw_idx_q : ar_idx_q;

  axil_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (w_strb_q),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (w_dat_q),
    .rdata_o (ram_rdata)
  );

  // Access FSM with registered B/R outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (go_rd) begin
            state_q <= ST_RD_WAIT;
            if (wr_pend) last_rd_q <= 1'b1;
          end else if (go_wr) begin
            state_q <= ST_WR_WAIT;
            if (rd_pend) last_rd_q <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (wait_done) begin
            state_q  <= ST_WR_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= aw_ok_q ? RESP_OKAY : RESP_DECERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (wait_done) begin
            state_q  <= ST_RD_RESP;
            rvalid_q <= 1'b1;
            rresp_q  <= ar_ok_q ? RESP_OKAY : RESP_DECERR;
            rdata_q  <= ar_ok_q ? ram_rdata : 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed self-checking bench for axil_mem_slave (BASE 0x01000000, ADDR_W 10, LATENCY 2).
// Expected values are hand-derived; build with AXIL_MEM_DECERR_EN to check the decode variant.
module tb_axil_mem_slave;

  logic        clk, rst;
  logic [31:0] awaddr, wdata, araddr;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic [3:0]  wstrb;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

  axil_mem_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_aw_rdy();
    int n = 0;
    while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin tests++; errs++; $display("FAIL aw_ready_timeout got %b want 1", awready); end
  endtask

  task automatic wait_w_rdy();
    int n = 0;
    while (wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin tests++; errs++; $display("FAIL w_ready_timeout got %b want 1", wready); end
  endtask

  task automatic wait_ar_rdy();
    int n = 0;
    while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin tests++; errs++; $display("FAIL ar_ready_timeout got %b want 1", arready); end
  endtask

  // Wait for bvalid, record response and cycle, then complete the handshake
  task automatic take_b(output logic [1:0] resp, output int seen);
    int n = 0;
    while (bvalid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin tests++; errs++; $display("FAIL b_timeout got bvalid=%b want 1", bvalid); end
    resp = bresp;
    seen = cyc;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit aw_first, output logic [1:0] resp, output int lat);
    int hs, seen;
    if (aw_first) begin
      awaddr = a; awvalid = 1'b1;
      wait_aw_rdy();
      @(posedge clk); #1; awvalid = 1'b0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      wait_w_rdy();
      @(posedge clk); #1; wvalid = 1'b0;
    end else begin
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
      wait_aw_rdy(); wait_w_rdy();
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    end
    hs = cyc;
    take_b(resp, seen);
    lat = seen - hs;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int hs, n;
    araddr = a; arvalid = 1'b1;
    wait_ar_rdy();
    @(posedge clk); #1; arvalid = 1'b0;
    hs = cyc;
    n = 0;
    while (rvalid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin tests++; errs++; $display("FAIL r_timeout got rvalid=%b want 1", rvalid); end
    lat = cyc - hs;
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Hold both response readies high and note which response arrives first
  task automatic collect(output int b_at, output int r_at, output logic [31:0] rcap);
    int n = 0;
    b_at = -1; r_at = -1; rcap = '0;
    bready = 1'b1; rready = 1'b1;
    while ((b_at < 0 || r_at < 0) && n < 100) begin
      if (bvalid === 1'b1 && b_at < 0) b_at = cyc;
      if (rvalid === 1'b1 && r_at < 0) begin r_at = cyc; rcap = rdata; end
      @(posedge clk); #1; n++;
    end
    bready = 1'b0; rready = 1'b0;
    if (n >= 100) begin tests++; errs++; $display("FAIL collect_timeout got b_at=%0d r_at=%0d want both >=0", b_at, r_at); end
  endtask

  task automatic test_reset();
    #1;
    tests++; if ({awready, wready, arready} !== 3'b000) begin errs++; $display("FAIL reset_readies got %b want 000", {awready, wready, arready}); end
    tests++; if ({bvalid, rvalid} !== 2'b00) begin errs++; $display("FAIL reset_valids got %b want 00", {bvalid, rvalid}); end
    tests++; if ({bresp, rresp, rdata} !== 36'h0) begin errs++; $display("FAIL reset_payload got %h want 0", {bresp, rresp, rdata}); end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    tests++; if (awready !== 1'b0) begin errs++; $display("FAIL ready_before_edge got %b want 0", awready); end
    @(posedge clk); #1;
    tests++; if ({awready, wready, arready} !== 3'b111) begin errs++; $display("FAIL ready_after_edge got %b want 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic();
    logic [1:0] r; int lat; logic [31:0] d;
    axi_write(32'h01000000, 32'h000000AA, 4'hF, 1'b1, r, lat);
    tests++; if (r !== 2'b00) begin errs++; $display("FAIL basic_bresp got %b want 00", r); end
    tests++; if (lat !== 4) begin errs++; $display("FAIL basic_b_latency got %0d want 4", lat); end
    axi_read(32'h01000000, d, r, lat);
    tests++; if (d !== 32'h000000AA) begin errs++; $display("FAIL basic_rdata got %h want 000000aa", d); end
    tests++; if (r !== 2'b00) begin errs++; $display("FAIL basic_rresp got %b want 00", r); end
    tests++; if (lat !== 4) begin errs++; $display("FAIL basic_r_latency got %0d want 4", lat); end
  endtask

  task automatic test_strobes();
    logic [1:0] r; int lat; logic [31:0] d;
    axi_write(32'h01000010, 32'hFFFFFFFF, 4'hF, 1'b0, r, lat);
    axi_write(32'h01000010, 32'h0000BBBB, 4'b0011, 1'b0, r, lat);
    tests++; if (lat !== 4) begin errs++; $display("FAIL strb_same_cycle_latency got %0d want 4", lat); end
    axi_read(32'h01000010, d, r, lat);
    tests++; if (d !== 32'hFFFFBBBB) begin errs++; $display("FAIL strb_merge got %h want ffffbbbb", d); end
    axi_write(32'h01000010, 32'h12345678, 4'b0000, 1'b0, r, lat);
    tests++; if (r !== 2'b00) begin errs++; $display("FAIL strb_zero_bresp got %b want 00", r); end
    axi_read(32'h01000013, d, r, lat);
    tests++; if (d !== 32'hFFFFBBBB) begin errs++; $display("FAIL strb_zero_noop got %h want ffffbbbb", d); end
  endtask

  task automatic test_range();
    logic [1:0] br, rr; int lat; logic [31:0] d, d0;
    axi_write(32'h0F000000, 32'hFFFFFFFF, 4'hF, 1'b0, br, lat);
    tests++; if (lat !== 4) begin errs++; $display("FAIL range_b_latency got %0d want 4", lat); end
    axi_read(32'h0F000000, d, rr, lat);
    axi_read(32'h01000000, d0, rr, lat);
    axi_read(32'h0F000000, d, rr, lat);
`ifdef AXIL_MEM_DECERR_EN
    tests++; if (br !== 2'b11) begin errs++; $display("FAIL range_bresp got %b want 11", br); end
    tests++; if (rr !== 2'b11) begin errs++; $display("FAIL range_rresp got %b want 11", rr); end
    tests++; if (d !== 32'h0) begin errs++; $display("FAIL range_rdata got %h want 00000000", d); end
    tests++; if (d0 !== 32'h000000AA) begin errs++; $display("FAIL range_word0 got %h want 000000aa", d0); end
`else
    tests++; if (br !== 2'b00) begin errs++; $display("FAIL alias_bresp got %b want 00", br); end
    tests++; if (rr !== 2'b00) begin errs++; $display("FAIL alias_rresp got %b want 00", rr); end
    tests++; if (d !== 32'hFFFFFFFF) begin errs++; $display("FAIL alias_rdata got %h want ffffffff", d); end
    tests++; if (d0 !== 32'hFFFFFFFF) begin errs++; $display("FAIL alias_word0 got %h want ffffffff", d0); end
`endif
  endtask

  task automatic test_arbitration();
    logic [1:0] r; int lat, b_at, r_at; logic [31:0] rcap, d;
    axi_write(32'h01000020, 32'h11111111, 4'hF, 1'b0, r, lat);
    // Round 1: read wins
    awaddr = 32'h01000020; wdata = 32'h22222222; wstrb = 4'hF; araddr = 32'h01000020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_aw_rdy(); wait_w_rdy(); wait_ar_rdy();
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    collect(b_at, r_at, rcap);
    tests++; if (!(r_at >= 0 && r_at < b_at)) begin errs++; $display("FAIL arb1_order got r_at=%0d b_at=%0d want read first", r_at, b_at); end
    tests++; if (rcap !== 32'h11111111) begin errs++; $display("FAIL arb1_rdata got %h want 11111111", rcap); end
    // Round 2: write wins
    awaddr = 32'h01000024; wdata = 32'h33333333; wstrb = 4'hF; araddr = 32'h01000024;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    wait_aw_rdy(); wait_w_rdy(); wait_ar_rdy();
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    collect(b_at, r_at, rcap);
    tests++; if (!(b_at >= 0 && b_at < r_at)) begin errs++; $display("FAIL arb2_order got b_at=%0d r_at=%0d want write first", b_at, r_at); end
    tests++; if (rcap !== 32'h33333333) begin errs++; $display("FAIL arb2_rdata got %h want 33333333", rcap); end
    axi_read(32'h01000020, d, r, lat);
    tests++; if (d !== 32'h22222222) begin errs++; $display("FAIL arb1_write_lost got %h want 22222222", d); end
  endtask

  task automatic test_b_backpressure();
    logic [1:0] r; int lat, n, seen; logic [31:0] d; int bad;
    awaddr = 32'h01000030; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw_rdy(); wait_w_rdy();
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    tests++; if (bvalid !== 1'b1) begin errs++; $display("FAIL bp_bvalid_rise got %b want 1", bvalid); end
    awaddr = 32'h01000034; awvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) bad++;
    end
    tests++; if (bad !== 0) begin errs++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    tests++; if ({bvalid, awready} !== 2'b01) begin errs++; $display("FAIL bp_release got bvalid,awready=%b want 01", {bvalid, awready}); end
    @(posedge clk); #1;
    tests++; if (awready !== 1'b0) begin errs++; $display("FAIL bp_new_aw_accept got %b want 0", awready); end
    awvalid = 1'b0;
    wdata = 32'h6C6C6C6C; wstrb = 4'hF; wvalid = 1'b1;
    wait_w_rdy();
    @(posedge clk); #1; wvalid = 1'b0;
    take_b(r, seen);
    axi_read(32'h01000034, d, r, lat);
    tests++; if (d !== 32'h6C6C6C6C) begin errs++; $display("FAIL bp_second_write got %h want 6c6c6c6c", d); end
    axi_read(32'h01000030, d, r, lat);
    tests++; if (d !== 32'h5A5A5A5A) begin errs++; $display("FAIL bp_first_write got %h want 5a5a5a5a", d); end
  endtask

  task automatic test_reset_midop();
    logic [1:0] r; int lat; logic [31:0] d; int bad;
    // Reset while in RD_WAIT
    araddr = 32'h01000010; arvalid = 1'b1;
    wait_ar_rdy();
    @(posedge clk); #1; arvalid = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++; if ({awready, wready, arready, rvalid} !== 4'b0000) begin errs++; $display("FAIL rst_rd_immediate got %b want 0000", {awready, wready, arready, rvalid}); end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    tests++; if (arready !== 1'b0) begin errs++; $display("FAIL rst_rd_ready_early got %b want 0", arready); end
    @(posedge clk); #1;
    tests++; if ({awready, wready, arready} !== 3'b111) begin errs++; $display("FAIL rst_rd_ready_return got %b want 111", {awready, wready, arready}); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid !== 1'b0 || bvalid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    tests++; if (bad !== 0) begin errs++; $display("FAIL rst_rd_no_resp got %0d bad cycles want 0", bad); end
    // Reset while in WR_WAIT: the write must be dropped
    awaddr = 32'h01000010; wdata = 32'h00000000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    wait_aw_rdy(); wait_w_rdy();
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (bvalid !== 1'b0) begin errs++; $display("FAIL rst_wr_no_bvalid got %b want 0", bvalid); end
    axi_read(32'h01000010, d, r, lat);
    tests++; if (d !== 32'hFFFFBBBB) begin errs++; $display("FAIL rst_ram_unchanged got %h want ffffbbbb", d); end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    test_reset();
    test_basic();
    test_strobes();
    test_range();
    test_arbitration();
    test_b_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
